// File: rtl/step_sched_pkg.sv
// Shared types, defaults and helpers for the step scheduler.
package step_sched_pkg;

  // Controller state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default number of clock cycles per speed unit.
  localparam int unsigned DEF_BASE_DIV = 32'd4;

  // Step period in clock cycles for a given speed code.
  function automatic int unsigned period(input logic [2:0] spd,
                                         input int unsigned base_div = DEF_BASE_DIV);
    return base_div * (32'(spd) + 32'd1);
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running prescaler that strobes once per programmed period while enabled.
module step_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             i_ck,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [PRE_W-1:0] i_period,
  output logic             o_tc
);

  localparam logic [PRE_W-1:0] ONE = PRE_W'(1);

  logic [PRE_W-1:0] r_cnt;

  // Terminal count only counts while the controller is actually advancing.
  assign o_tc = i_run && (r_cnt == (i_period - ONE));

  // Counter: clear on command, wrap at terminal count, freeze when not running.
  always_ff @(posedge i_ck or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (o_tc) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/step_sched_ctrl.sv
// Step scheduler: paces step_en pulses, counts steps against a limit,
// and handles run/hold/single-step/stop commands.
module step_sched_ctrl
  import step_sched_pkg::*;
#(
  parameter int unsigned BASE_DIV = DEF_BASE_DIV,
  parameter int          CNT_W    = 8,
  parameter int          PRE_W    = 16
) (
  input  logic             i_ck,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_hold,
  input  logic             i_step,
  input  logic [2:0]       i_speed,
  input  logic [CNT_W-1:0] i_num_steps,
  output logic             o_step_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_step_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_speed;
  logic [2:0]       w_speed_nxt;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] w_limit_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_step_en;
  logic             w_step_en_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_clr;
  logic             w_run;
  logic             w_tc;
  logic             w_hit;
  logic [PRE_W-1:0] w_period;

  assign w_period  = PRE_W'(period(r_speed, BASE_DIV));
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_hit     = (r_limit != '0) && (w_cnt_inc == r_limit);

  // Prescaler advances only in RUN with no higher-priority command pending,
  // so stop/start/hold coinciding with terminal count suppress the step.
  assign w_run = (r_state == ST_RUN) && !i_stop && !i_start && !i_hold;

  step_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .i_ck     (i_ck),
    .i_reset  (i_reset),
    .i_clr    (w_clr),
    .i_run    (w_run),
    .i_period (w_period),
    .o_tc     (w_tc)
  );

  // Next-state and output decode; stop > start > step > hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_speed_nxt   = r_speed;
    w_limit_nxt   = r_limit;
    w_cnt_nxt     = r_cnt;
    w_step_en_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_clr         = 1'b0;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
      w_clr       = 1'b1;
    end else if (i_start) begin
      w_state_nxt = ST_RUN;
      w_speed_nxt = i_speed;
      w_limit_nxt = i_num_steps;
      w_cnt_nxt   = '0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Manual step in IDLE drives the generator but is not counted.
          if (i_step) begin
            w_step_en_nxt = 1'b1;
          end else begin
            w_step_en_nxt = 1'b0;
          end
        end
        ST_RUN: begin
          if (i_hold) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_tc) begin
            w_step_en_nxt = 1'b1;
            w_cnt_nxt     = w_cnt_inc;
            w_speed_nxt   = i_speed;
            if (w_hit) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (i_step) begin
            w_step_en_nxt = 1'b1;
            w_cnt_nxt     = w_cnt_inc;
            if (w_hit) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_PAUSE;
            end
          end else if (!i_hold) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_ck or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched run parameters, step counter and registered pulse outputs.
  always_ff @(posedge i_ck or negedge i_reset) begin
    if (!i_reset) begin
      r_speed   <= 3'd0;
      r_limit   <= '0;
      r_cnt     <= '0;
      r_step_en <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_speed   <= w_speed_nxt;
      r_limit   <= w_limit_nxt;
      r_cnt     <= w_cnt_nxt;
      r_step_en <= w_step_en_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_busy     = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign o_step_en  = r_step_en;
  assign o_done     = r_done;
  assign o_step_cnt = r_cnt;

endmodule

// File: tb/tb_step_sched_ctrl.sv
// Directed self-checking bench for step_sched_ctrl (BASE_DIV=4, CNT_W=8).
module tb_step_sched_ctrl;

  logic       ck = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       hold;
  logic       step;
  logic [2:0] speed;
  logic [7:0] num_steps;
  logic       step_en;
  logic       busy;
  logic       done;
  logic [7:0] step_cnt;

  int checks   = 0;
  int failures = 0;

  step_sched_ctrl #(.BASE_DIV(4), .CNT_W(8), .PRE_W(16)) dut (
    .i_ck        (ck),
    .i_reset     (reset),
    .i_start     (start),
    .i_stop      (stop),
    .i_hold      (hold),
    .i_step      (step),
    .i_speed     (speed),
    .i_num_steps (num_steps),
    .o_step_en   (step_en),
    .o_busy      (busy),
    .o_done      (done),
    .o_step_cnt  (step_cnt)
  );

  always #5 ck = ~ck;

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic do_start(input logic [2:0] spd, input logic [7:0] lim);
    speed = spd; num_steps = lim; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; step = 1'b0;
    speed = 3'd0; num_steps = 8'd0;
    #3;
    checks++;
    if ({step_en, busy, done, step_cnt} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got en=%0b busy=%0b done=%0b cnt=%0d exp all 0", step_en, busy, done, step_cnt);
    end
    tick; tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_limit_run;
    logic       exp_en;
    logic [7:0] exp_cnt;
    do_start(3'd1, 8'd3);
    for (int c = 1; c <= 30; c++) begin
      tick;
      exp_en  = (c == 8) || (c == 16) || (c == 24);
      exp_cnt = (c < 8) ? 8'd0 : (c < 16) ? 8'd1 : (c < 24) ? 8'd2 : 8'd3;
      checks++;
      if (step_en !== exp_en) begin
        failures++; $display("FAIL limit_step_en cycle=%0d got=%0b exp=%0b", c, step_en, exp_en);
      end
      checks++;
      if (step_cnt !== exp_cnt) begin
        failures++; $display("FAIL limit_step_cnt cycle=%0d got=%0d exp=%0d", c, step_cnt, exp_cnt);
      end
      checks++;
      if (done !== (c == 24)) begin
        failures++; $display("FAIL limit_done cycle=%0d got=%0b exp=%0b", c, done, (c == 24));
      end
      if (c != 24) begin
        checks++;
        if (busy !== (c < 24)) begin
          failures++; $display("FAIL limit_busy cycle=%0d got=%0b exp=%0b", c, busy, (c < 24));
        end
      end
    end
  endtask

  task automatic test_free_run_wrap;
    logic [7:0] exp_cnt;
    do_start(3'd0, 8'd0);
    for (int c = 1; c <= 1030; c++) begin
      tick;
      exp_cnt = 8'(c / 4);
      checks++;
      if (step_en !== ((c % 4) == 0)) begin
        failures++; $display("FAIL free_step_en cycle=%0d got=%0b exp=%0b", c, step_en, ((c % 4) == 0));
      end
      checks++;
      if (step_cnt !== exp_cnt) begin
        failures++; $display("FAIL free_step_cnt cycle=%0d got=%0d exp=%0d", c, step_cnt, exp_cnt);
      end
      checks++;
      if (done !== 1'b0) begin
        failures++; $display("FAIL free_done cycle=%0d got=%0b exp=0", c, done);
      end
    end
  endtask

  task automatic test_speed_change;
    do_start(3'd0, 8'd0);
    for (int c = 1; c <= 40; c++) begin
      tick;
      checks++;
      if (step_en !== ((c == 4) || (c == 36))) begin
        failures++; $display("FAIL speed_step_en cycle=%0d got=%0b exp=%0b", c, step_en, ((c == 4) || (c == 36)));
      end
      if (c == 2) speed = 3'd7;
    end
    checks++;
    if (step_cnt !== 8'd2) begin
      failures++; $display("FAIL speed_step_cnt got=%0d exp=2", step_cnt);
    end
  endtask

  task automatic test_hold_step;
    do_start(3'd1, 8'd0);
    for (int c = 1; c <= 24; c++) begin
      tick;
      checks++;
      if (step_en !== ((c == 11) || (c == 19))) begin
        failures++; $display("FAIL hold_step_en cycle=%0d got=%0b exp=%0b", c, step_en, ((c == 11) || (c == 19)));
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL hold_busy cycle=%0d got=%0b exp=1", c, busy);
      end
      if (c == 11 || c == 19) begin
        checks++;
        if (step_cnt !== ((c == 11) ? 8'd1 : 8'd2)) begin
          failures++; $display("FAIL hold_step_cnt cycle=%0d got=%0d exp=%0d", c, step_cnt, ((c == 11) ? 1 : 2));
        end
      end
      if (c == 5)  hold = 1'b1;
      if (c == 15) hold = 1'b0;
      step = (c == 10);
    end
    step = 1'b0;
  endtask

  task automatic test_stop_at_tc;
    logic [7:0] exp_cnt;
    do_start(3'd0, 8'd0);
    for (int c = 1; c <= 20; c++) begin
      tick;
      exp_cnt = (c < 4) ? 8'd0 : (c < 8) ? 8'd1 : 8'd2;
      checks++;
      if (step_en !== ((c == 4) || (c == 8))) begin
        failures++; $display("FAIL stop_step_en cycle=%0d got=%0b exp=%0b", c, step_en, ((c == 4) || (c == 8)));
      end
      checks++;
      if (step_cnt !== exp_cnt) begin
        failures++; $display("FAIL stop_step_cnt cycle=%0d got=%0d exp=%0d", c, step_cnt, exp_cnt);
      end
      checks++;
      if (busy !== (c < 12)) begin
        failures++; $display("FAIL stop_busy cycle=%0d got=%0b exp=%0b", c, busy, (c < 12));
      end
      stop = (c == 11);
    end
    stop = 1'b0;
    // Manual step in IDLE: pulse issued, count untouched.
    step = 1'b1;
    tick;
    step = 1'b0;
    checks++;
    if ({step_en, busy, step_cnt} !== {1'b1, 1'b0, 8'd2}) begin
      failures++; $display("FAIL idle_step got en=%0b busy=%0b cnt=%0d exp en=1 busy=0 cnt=2", step_en, busy, step_cnt);
    end
    tick;
    checks++;
    if (step_en !== 1'b0) begin
      failures++; $display("FAIL idle_step_single got=%0b exp=0", step_en);
    end
  endtask

  task automatic test_limit_manual;
    do_start(3'd3, 8'd1);
    tick;
    hold = 1'b1;
    tick; tick;
    step = 1'b1;
    tick;
    step = 1'b0;
    checks++;
    if ({step_en, done, busy, step_cnt} !== {1'b1, 1'b1, 1'b0, 8'd1}) begin
      failures++; $display("FAIL manual_limit got en=%0b done=%0b busy=%0b cnt=%0d exp en=1 done=1 busy=0 cnt=1", step_en, done, busy, step_cnt);
    end
    hold = 1'b0;
    step = 1'b1;
    tick;
    step = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if ({step_en, done, busy, step_cnt} !== {1'b0, 1'b0, 1'b0, 8'd1}) begin
        failures++; $display("FAIL done_hold cycle=%0d got en=%0b done=%0b busy=%0b cnt=%0d exp 0 0 0 1", c, step_en, done, busy, step_cnt);
      end
      tick;
    end
  endtask

  task automatic test_async_reset;
    do_start(3'd0, 8'd0);
    tick; tick; tick; tick;
    checks++;
    if (step_en !== 1'b1) begin
      failures++; $display("FAIL areset_pre_step got=%0b exp=1", step_en);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({step_en, busy, done, step_cnt} !== 11'd0) begin
      failures++; $display("FAIL areset_outputs got en=%0b busy=%0b done=%0b cnt=%0d exp all 0", step_en, busy, done, step_cnt);
    end
    #1 reset = 1'b1;
    tick;
    do_start(3'd2, 8'd0);
    for (int c = 1; c <= 14; c++) begin
      tick;
      checks++;
      if (step_en !== (c == 12)) begin
        failures++; $display("FAIL areset_cold_step_en cycle=%0d got=%0b exp=%0b", c, step_en, (c == 12));
      end
      checks++;
      if (step_cnt !== ((c >= 12) ? 8'd1 : 8'd0)) begin
        failures++; $display("FAIL areset_cold_cnt cycle=%0d got=%0d exp=%0d", c, step_cnt, ((c >= 12) ? 1 : 0));
      end
    end
  endtask

  initial begin
    test_reset;
    test_limit_run;
    test_free_run_wrap;
    test_speed_change;
    test_hold_step;
    test_stop_at_tc;
    test_limit_manual;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
